// File: rtl/posit_lane_scheduler.sv
// Round-robin dispatcher feeding NUM_LANES posit_unit lanes, with a reorder
// buffer that returns lane results strictly in acceptance order.
module posit_lane_scheduler #(
  parameter int NUM_LANES = 4,
  parameter int ROB_DEPTH = 8,
  parameter int DATA_W    = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [DATA_W-1:0]             in_a_i,
  input  logic [DATA_W-1:0]             in_b_i,
  input  logic [1:0]                    in_op_i,
  output logic [NUM_LANES-1:0]          lane_start_o,
  output logic [NUM_LANES*DATA_W-1:0]   lane_a_o,
  output logic [NUM_LANES*DATA_W-1:0]   lane_b_o,
  output logic [NUM_LANES*2-1:0]        lane_op_o,
  input  logic [NUM_LANES-1:0]          lane_done_i,
  input  logic [NUM_LANES*DATA_W-1:0]   lane_out_i,
  input  logic [NUM_LANES-1:0]          lane_inf_i,
  input  logic [NUM_LANES-1:0]          lane_zero_i,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [DATA_W-1:0]             res_data_o,
  output logic                          res_inf_o,
  output logic                          res_zero_o,
  output logic                          busy_o
);

  localparam int TAG_W = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;
  localparam int CNT_W = $clog2(ROB_DEPTH + 1);
  localparam int LN_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  // Lane-side state
  logic [NUM_LANES-1:0] busy_reg;
  logic [NUM_LANES-1:0] start_reg;
  logic [TAG_W-1:0]     tag_reg    [NUM_LANES];
  logic [DATA_W-1:0]    lane_a_reg [NUM_LANES];
  logic [DATA_W-1:0]    lane_b_reg [NUM_LANES];
  logic [1:0]           lane_op_reg[NUM_LANES];

  // Reorder buffer
  logic [DATA_W-1:0]    rob_data_reg [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] rob_valid_reg;
  logic [ROB_DEPTH-1:0] rob_inf_reg;
  logic [ROB_DEPTH-1:0] rob_zero_reg;
  logic [TAG_W-1:0]     head_reg;
  logic [TAG_W-1:0]     tail_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [LN_W-1:0]      rr_ptr_reg;
  // Holds acceptance off until the first clock after reset release.
  logic                 run_reg;

  logic                 lane_free;
  logic [LN_W-1:0]      sel_lane;
  logic [LN_W-1:0]      sel_next;
  logic [LN_W:0]        scan_idx;
  logic                 xfer;
  logic                 pop;

  // First idle lane at or above rr_ptr, wrapping.
  always_comb begin
    lane_free = 1'b0;
    sel_lane  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      scan_idx = {1'b0, rr_ptr_reg} + (LN_W+1)'(k);
      if (scan_idx >= (LN_W+1)'(NUM_LANES)) begin
        scan_idx = scan_idx - (LN_W+1)'(NUM_LANES);
      end
      if (!lane_free && !busy_reg[scan_idx[LN_W-1:0]]) begin
        lane_free = 1'b1;
        sel_lane  = scan_idx[LN_W-1:0];
      end
    end
  end

  always_comb begin
    sel_next = sel_lane + 1'b1;
    if (sel_lane == LN_W'(NUM_LANES - 1)) begin
      sel_next = '0;
    end
  end

  assign in_ready_o  = run_reg && lane_free && (count_reg < CNT_W'(ROB_DEPTH));
  assign xfer        = in_valid_i && in_ready_o;
  assign res_valid_o = rob_valid_reg[head_reg];
  assign res_data_o  = rob_data_reg[head_reg];
  assign res_inf_o   = rob_inf_reg[head_reg];
  assign res_zero_o  = rob_zero_reg[head_reg];
  assign pop         = res_valid_o && res_ready_i;
  assign busy_o      = (count_reg != '0);
  assign lane_start_o = start_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane_pack
      assign lane_a_o[gi*DATA_W +: DATA_W] = lane_a_reg[gi];
      assign lane_b_o[gi*DATA_W +: DATA_W] = lane_b_reg[gi];
      assign lane_op_o[gi*2 +: 2]          = lane_op_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_reg       <= 1'b0;
      busy_reg      <= '0;
      start_reg     <= '0;
      rob_valid_reg <= '0;
      rob_inf_reg   <= '0;
      rob_zero_reg  <= '0;
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      rr_ptr_reg    <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        tag_reg[l]     <= '0;
        lane_a_reg[l]  <= '0;
        lane_b_reg[l]  <= '0;
        lane_op_reg[l] <= '0;
      end
      for (int e = 0; e < ROB_DEPTH; e++) begin
        rob_data_reg[e] <= '0;
      end
    end else begin
      run_reg   <= 1'b1;
      start_reg <= '0;

      if (xfer) begin
        busy_reg[sel_lane]    <= 1'b1;
        start_reg[sel_lane]   <= 1'b1;
        tag_reg[sel_lane]     <= tail_reg;
        lane_a_reg[sel_lane]  <= in_a_i;
        lane_b_reg[sel_lane]  <= in_b_i;
        lane_op_reg[sel_lane] <= in_op_i;
        rob_valid_reg[tail_reg] <= 1'b0;
        tail_reg   <= tail_reg + 1'b1;
        rr_ptr_reg <= sel_next;
      end

      if (pop) begin
        rob_valid_reg[head_reg] <= 1'b0;
        head_reg <= head_reg + 1'b1;
      end

      // Completing tags never collide with tail or head: both are free or already valid.
      for (int l = 0; l < NUM_LANES; l++) begin
        if (lane_done_i[l] && busy_reg[l]) begin
          busy_reg[l]                 <= 1'b0;
          rob_data_reg[tag_reg[l]]    <= lane_out_i[l*DATA_W +: DATA_W];
          rob_inf_reg[tag_reg[l]]     <= lane_inf_i[l];
          rob_zero_reg[tag_reg[l]]    <= lane_zero_i[l];
          rob_valid_reg[tag_reg[l]]   <= 1'b1;
        end
      end

      case ({xfer, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_posit_lane_scheduler.sv
// Directed bench for posit_lane_scheduler: dispatch order, in-order return,
// ROB-full backpressure, simultaneous completion, round-robin skip and reset.
module tb_posit_lane_scheduler;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [31:0]   in_a_i;
  logic [31:0]   in_b_i;
  logic [1:0]    in_op_i;
  logic [3:0]    lane_start_o;
  logic [127:0]  lane_a_o;
  logic [127:0]  lane_b_o;
  logic [7:0]    lane_op_o;
  logic [3:0]    lane_done_i;
  logic [127:0]  lane_out_i;
  logic [3:0]    lane_inf_i;
  logic [3:0]    lane_zero_i;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [31:0]   res_data_o;
  logic          res_inf_o;
  logic          res_zero_o;
  logic          busy_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  posit_lane_scheduler dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_a_i(in_a_i), .in_b_i(in_b_i), .in_op_i(in_op_i),
    .lane_start_o(lane_start_o), .lane_a_o(lane_a_o), .lane_b_o(lane_b_o),
    .lane_op_o(lane_op_o), .lane_done_i(lane_done_i), .lane_out_i(lane_out_i),
    .lane_inf_i(lane_inf_i), .lane_zero_i(lane_zero_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .res_inf_o(res_inf_o), .res_zero_o(res_zero_o), .busy_o(busy_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] a);
    in_valid_i = 1'b1;
    in_a_i     = a;
    in_b_i     = ~a;
    in_op_i    = a[1:0];
    tick();
    in_valid_i = 1'b0;
    $display("[TB] push a=%h lane_start=%b", a, lane_start_o);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; in_valid_i = 1'b0; in_a_i = '0; in_b_i = '0; in_op_i = '0;
    lane_done_i = '0; lane_out_i = '0; lane_inf_i = '0; lane_zero_i = '0; res_ready_i = 1'b0;
    #3;
    tests_run++;
    if ({in_ready_o, lane_start_o, res_valid_o, res_inf_o, res_zero_o, busy_o} !== 9'd0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 0", {in_ready_o, lane_start_o, res_valid_o, res_inf_o, res_zero_o, busy_o});
    end
    tests_run++;
    if ({lane_a_o, lane_b_o, lane_op_o, res_data_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got nonzero data outputs, want 0");
    end
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    tests_run++;
    if (in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: got ready=%b busy=%b want ready=1 busy=0", in_ready_o, busy_o);
    end
  endtask

  task automatic test_dispatch();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (in_ready_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL disp_ready%0d: got %b want 1", i, in_ready_o);
      end
      in_valid_i = 1'b1; in_a_i = 32'(i + 1); in_b_i = 32'h100 + 32'(i); in_op_i = 2'(i);
      tick();
      $display("[TB] accept a=%0d lane_start=%b", i + 1, lane_start_o);
      tests_run++;
      if (lane_start_o !== 4'(1 << i)) begin
        tests_failed++;
        $display("FAIL disp_start%0d: got %b want %b", i, lane_start_o, 4'(1 << i));
      end
      tests_run++;
      if (lane_a_o[i*32 +: 32] !== 32'(i + 1) || lane_b_o[i*32 +: 32] !== 32'h100 + 32'(i)
          || lane_op_o[i*2 +: 2] !== 2'(i)) begin
        tests_failed++;
        $display("FAIL disp_operands%0d: got a=%h b=%h op=%0d want a=%h b=%h op=%0d", i,
                 lane_a_o[i*32 +: 32], lane_b_o[i*32 +: 32], lane_op_o[i*2 +: 2],
                 i + 1, 32'h100 + 32'(i), i % 4);
      end
    end
    in_valid_i = 1'b0;
    tests_run++;
    if (in_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL disp_all_busy: got ready=%b want 0", in_ready_o);
    end
    tick();
    tests_run++;
    if (lane_start_o !== 4'b0000 || in_ready_o !== 1'b0 || lane_a_o[31:0] !== 32'd1) begin
      tests_failed++;
      $display("FAIL disp_hold: got start=%b ready=%b a0=%h want 0000 0 1", lane_start_o, in_ready_o, lane_a_o[31:0]);
    end
  endtask

  task automatic test_out_of_order();
    res_ready_i = 1'b1;
    lane_done_i = 4'b0100; lane_out_i[64 +: 32] = 32'h30;
    tick(); lane_done_i = '0;
    tests_run++;
    if (res_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL ooo_wait_lane0: got valid=%b want 0", res_valid_o);
    end
    lane_done_i = 4'b0001; lane_out_i[0 +: 32] = 32'h10; lane_zero_i = 4'b0001;
    tick(); lane_done_i = '0; lane_zero_i = '0;
    tests_run++;
    if (res_valid_o !== 1'b1 || res_data_o !== 32'h10 || res_zero_o !== 1'b1 || res_inf_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL ooo_first: got v=%b d=%h z=%b i=%b want 1 10 1 0", res_valid_o, res_data_o, res_zero_o, res_inf_o);
    end
    $display("[TB] result %h", res_data_o);
    lane_done_i = 4'b1000; lane_out_i[96 +: 32] = 32'h40; lane_inf_i = 4'b1000;
    tick(); lane_done_i = '0; lane_inf_i = '0;
    tests_run++;
    if (res_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL ooo_wait_lane1: got valid=%b want 0", res_valid_o);
    end
    lane_done_i = 4'b0010; lane_out_i[32 +: 32] = 32'h20;
    tick(); lane_done_i = '0;
    tests_run++;
    if (res_valid_o !== 1'b1 || res_data_o !== 32'h20) begin
      tests_failed++;
      $display("FAIL ooo_second: got v=%b d=%h want 1 20", res_valid_o, res_data_o);
    end
    $display("[TB] result %h", res_data_o);
    tick();
    tests_run++;
    if (res_valid_o !== 1'b1 || res_data_o !== 32'h30 || res_inf_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL ooo_third: got v=%b d=%h i=%b want 1 30 0", res_valid_o, res_data_o, res_inf_o);
    end
    $display("[TB] result %h", res_data_o);
    tick();
    tests_run++;
    if (res_valid_o !== 1'b1 || res_data_o !== 32'h40 || res_inf_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL ooo_fourth: got v=%b d=%h i=%b want 1 40 1", res_valid_o, res_data_o, res_inf_o);
    end
    $display("[TB] result %h", res_data_o);
    tick();
    tests_run++;
    if (res_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL ooo_drained: got valid=%b busy=%b want 0 0", res_valid_o, busy_o);
    end
    res_ready_i = 1'b0;
  endtask

  task automatic test_rob_full();
    res_ready_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (in_ready_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL full_accept%0d: got ready=%b want 1", k, in_ready_o);
      end
      in_valid_i = 1'b1; in_a_i = 32'h200 + 32'(k); in_b_i = '0; in_op_i = '0;
      tick();
      $display("[TB] accept a=%h lane_start=%b", 32'h200 + 32'(k), lane_start_o);
      lane_done_i = lane_start_o;
      for (int l = 0; l < 4; l++) lane_out_i[l*32 +: 32] = lane_a_o[l*32 +: 32] + 32'h1000;
    end
    in_valid_i = 1'b0;
    tick();
    lane_done_i = '0;
    tests_run++;
    if (in_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_ready_low: got ready=%b busy=%b want 0 1", in_ready_o, busy_o);
    end
    tests_run++;
    if (res_valid_o !== 1'b1 || res_data_o !== 32'h1200) begin
      tests_failed++;
      $display("FAIL full_head: got v=%b d=%h want 1 1200", res_valid_o, res_data_o);
    end
    tick();
    tests_run++;
    if (in_ready_o !== 1'b0 || res_data_o !== 32'h1200) begin
      tests_failed++;
      $display("FAIL full_hold: got ready=%b d=%h want 0 1200", in_ready_o, res_data_o);
    end
    res_ready_i = 1'b1;
    tests_run++;
    if (in_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_pop_cycle: got ready=%b want 0", in_ready_o);
    end
    tick();
    res_ready_i = 1'b0;
    tests_run++;
    if (in_ready_o !== 1'b1 || res_data_o !== 32'h1201) begin
      tests_failed++;
      $display("FAIL full_reopen: got ready=%b d=%h want 1 1201", in_ready_o, res_data_o);
    end
    res_ready_i = 1'b1;
    for (int k = 1; k < 8; k++) begin
      tests_run++;
      if (res_valid_o !== 1'b1 || res_data_o !== 32'h1200 + 32'(k)) begin
        tests_failed++;
        $display("FAIL full_drain%0d: got v=%b d=%h want 1 %h", k, res_valid_o, res_data_o, 32'h1200 + 32'(k));
      end
      $display("[TB] result %h", res_data_o);
      tick();
    end
    res_ready_i = 1'b0;
    tests_run++;
    if (res_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_empty: got v=%b busy=%b want 0 0", res_valid_o, busy_o);
    end
  endtask

  task automatic test_all_done();
    for (int k = 0; k < 4; k++) push(32'h300 + 32'(k));
    lane_done_i = 4'b1111;
    for (int l = 0; l < 4; l++) lane_out_i[l*32 +: 32] = 32'h500 + 32'(l);
    tick();
    lane_done_i = '0;
    tests_run++;
    if (in_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL alldone_ready: got %b want 1", in_ready_o);
    end
    res_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (res_valid_o !== 1'b1 || res_data_o !== 32'h500 + 32'(i)) begin
        tests_failed++;
        $display("FAIL alldone_pop%0d: got v=%b d=%h want 1 %h", i, res_valid_o, res_data_o, 32'h500 + 32'(i));
      end
      $display("[TB] result %h", res_data_o);
      tick();
    end
    res_ready_i = 1'b0;
    tests_run++;
    if (res_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL alldone_empty: got v=%b want 0", res_valid_o);
    end
  endtask

  task automatic test_rr_skip();
    for (int k = 0; k < 4; k++) push(32'h700 + 32'(k));
    lane_done_i = 4'b1101;
    for (int l = 0; l < 4; l++) lane_out_i[l*32 +: 32] = 32'h600 + 32'(l);
    tick(); lane_done_i = '0;
    push(32'h704);
    tests_run++;
    if (lane_start_o !== 4'b0001) begin
      tests_failed++;
      $display("FAIL rr_setup: got start=%b want 0001", lane_start_o);
    end
    lane_done_i = 4'b0001;
    tick(); lane_done_i = '0;
    push(32'h705);
    tests_run++;
    if (lane_start_o !== 4'b0100 || lane_a_o[64 +: 32] !== 32'h705) begin
      tests_failed++;
      $display("FAIL rr_skip: got start=%b a2=%h want 0100 705", lane_start_o, lane_a_o[64 +: 32]);
    end
    push(32'h706);
    tests_run++;
    if (lane_start_o !== 4'b1000) begin
      tests_failed++;
      $display("FAIL rr_after: got start=%b want 1000", lane_start_o);
    end
  endtask

  task automatic test_reset_mid();
    tests_run++;
    if (res_valid_o !== 1'b1 || busy_o !== 1'b1 || res_data_o !== 32'h600) begin
      tests_failed++;
      $display("FAIL mid_pre: got v=%b busy=%b d=%h want 1 1 600", res_valid_o, busy_o, res_data_o);
    end
    rst_ni = 1'b0;
    #1;
    tests_run++;
    if ({in_ready_o, lane_start_o, res_valid_o, res_inf_o, res_zero_o, busy_o} !== 9'd0
        || {lane_a_o, lane_b_o, lane_op_o, res_data_o} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got ctrl=%b data_nonzero=%b want 0 0",
               {in_ready_o, lane_start_o, res_valid_o, res_inf_o, res_zero_o, busy_o},
               ({lane_a_o, lane_b_o, lane_op_o, res_data_o} != '0));
    end
    tick();
    rst_ni = 1'b1;
    tick();
    lane_done_i = 4'b0001; lane_out_i[0 +: 32] = 32'hDEAD;
    tick(); lane_done_i = '0;
    tests_run++;
    if (res_valid_o !== 1'b0 || busy_o !== 1'b0 || in_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_spurious_done: got v=%b busy=%b ready=%b want 0 0 1", res_valid_o, busy_o, in_ready_o);
    end
    push(32'h800);
    tests_run++;
    if (lane_start_o !== 4'b0001 || res_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_rr_cleared: got start=%b v=%b want 0001 0", lane_start_o, res_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_out_of_order();
    test_rob_full();
    test_all_done();
    test_rr_skip();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/posit_lane_scheduler.md
Name: posit_lane_scheduler

Overview:
- Dispatches a single stream of posit operand pairs (a, b, op_code) across NUM_LANES posit_unit instances.
- Tags each issued operation, collects lane results as they complete, and returns them in strict issue order through a reorder buffer (ROB).
- Sits between the coprocessor bus/load logic and the SIMD posit_unit lanes, replacing fixed lane-per-slot assignment with dynamic round-robin sharing.

Parameters:
- NUM_LANES, 4, number of posit_unit lanes driven; 1 to 8; must be <= ROB_DEPTH.
- ROB_DEPTH, 8, reorder buffer entries; power of two, >= 2.
- DATA_W, 32, posit word width.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- in_valid_i  input  1  operand pair valid.
- in_ready_o  output  1  scheduler accepts the pair this cycle.
- in_a_i  input  DATA_W  operand a.
- in_b_i  input  DATA_W  operand b.
- in_op_i  input  2  posit op_code.
- lane_start_o  output  NUM_LANES  one-cycle start pulse, one bit per lane.
- lane_a_o  output  NUM_LANES*DATA_W  operand a per lane; lane l occupies bits [l*DATA_W +: DATA_W].
- lane_b_o  output  NUM_LANES*DATA_W  operand b per lane.
- lane_op_o  output  NUM_LANES*2  op_code per lane.
- lane_done_i  input  NUM_LANES  lane completion pulse.
- lane_out_i  input  NUM_LANES*DATA_W  lane result; valid while the matching done bit is high.
- lane_inf_i  input  NUM_LANES  lane inf flag; sampled with done.
- lane_zero_i  input  NUM_LANES  lane zero flag; sampled with done.
- res_valid_o  output  1  in-order result available.
- res_ready_i  input  1  consumer accepts the result.
- res_data_o  output  DATA_W  result word.
- res_inf_o  output  1  result inf flag.
- res_zero_o  output  1  result zero flag.
- busy_o  output  1  at least one operation issued and not yet popped.

Behaviour:
- Reset (async, rst_ni low):
  - All lane busy bits, ROB valid bits, head, tail, count and the round-robin pointer clear to 0.
  - All outputs are 0: in_ready_o, lane_start_o, lane_a_o, lane_b_o, lane_op_o, res_valid_o, res_data_o, res_inf_o, res_zero_o, busy_o.
  - Reset mid-operation discards all in-flight work. The lanes share rst_ni, so no stale done is expected.
- Lane state:
  - Each lane has a busy bit and a tag register of log2(ROB_DEPTH) bits.
  - One operation is outstanding per lane at most.
- Acceptance:
  - in_ready_o = (some lane not busy) AND (count < ROB_DEPTH).
  - in_ready_o is combinational from registers only; it does not depend on in_valid_i.
  - A transfer occurs when in_valid_i and in_ready_o are both high. At most one transfer per cycle.
- Lane selection:
  - Pick the first non-busy lane found by scanning upward from rr_ptr, wrapping modulo NUM_LANES.
  - After a dispatch, rr_ptr <= selected lane + 1 (mod NUM_LANES).
- Dispatch, at the edge ending a transfer cycle:
  - Lane registers load a, b and op.
  - lane_start_o[l] is asserted for exactly the following cycle.
  - busy[l] <= 1; tag[l] <= tail; tail <= tail + 1, wrapping at ROB_DEPTH.
  - rob_valid[tail] <= 0.
- Lane operand outputs hold their last dispatched values until the next dispatch to that lane.
- Completion:
  - lane_done_i[l] with busy[l] = 1 writes lane_out_i, inf and zero into ROB[tag[l]], sets rob_valid, and clears busy[l].
  - Multiple lanes may complete in the same cycle; all are captured.
  - A done on a non-busy lane is ignored.
  - A freed lane becomes eligible for acceptance in the cycle after its done.
- Output:
  - res_valid_o = rob_valid[head]; res_data_o, res_inf_o and res_zero_o = ROB[head] fields.
  - All of these are combinational from registers.
  - Pop on res_valid_o AND res_ready_i: rob_valid[head] <= 0; head <= head + 1, wrapping.
  - Results are held stable while res_valid_o is high and res_ready_i is low.
- Count:
  - Increments on transfer, decrements on pop, and is unchanged when both occur in the same cycle.
  - ROB full (count = ROB_DEPTH) deasserts in_ready_o even if a lane is free.
  - A pop in the same cycle as full does not raise in_ready_o until the next cycle.
- busy_o = (count != 0).
- Ordering: results leave in acceptance order regardless of lane completion order.

Test Plan:
- Reset release, then 4 pairs on consecutive cycles (a = 1..4) -> start pulses on lanes 0, 1, 2, 3 in cycles 1..4 (relative to the first transfer); in_ready_o low after the 4th accept until a done arrives.
- Done order lane 2, 0, 3, 1 with outs 0x30, 0x10, 0x40, 0x20, res_ready_i = 1 -> results emerge 0x10, 0x20, 0x30, 0x40; the first result appears only after lane 0's done.
- res_ready_i held 0, lanes completing immediately, 8 pairs pushed -> count reaches 8 and in_ready_o stays 0 with lanes idle; one pop and in_ready_o = 1 the next cycle.
- lane_done_i = 4'b1111 in one cycle -> all 4 ROB entries valid; 4 pops on 4 consecutive cycles.
- Lane 1 busy, rr_ptr = 1, lanes 0, 2 and 3 free, one transfer -> dispatch goes to lane 2 and rr_ptr becomes 3.
- rst_ni asserted low with 3 in flight -> all outputs 0 immediately; after release a spurious lane_done_i[0] is ignored and res_valid_o stays 0.
